// File: rtl/vedic_div_128x64.sv
// Sequential restoring divider: 128-bit dividend / 64-bit divisor, one
// quotient bit per clock. Sits beside the 64x64 Vedic multiplier so that
// products can be divided back down (a*b / b -> a, remainder 0).
//
// state | meaning
// IDLE  | waiting for start; results from the last operation are held
// CALC  | iterating, one quotient bit per cycle (busy=1)
// DONE  | one-cycle result strobe (done=1); a new start may be accepted here
module vedic_div_128x64 #(
  parameter int WIDTH = 64
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [2*WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0]   divisor,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   quotient,
  output logic [WIDTH-1:0]   remainder,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int CNT_W = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state;
  logic [WIDTH:0]   pr;       // partial remainder, one guard bit
  logic [WIDTH-1:0] sr;       // dividend low half shifts out, quotient bits shift in
  logic [WIDTH-1:0] dvs;      // captured divisor
  logic [CNT_W-1:0] cnt;

  logic [WIDTH:0]   pr_shift;
  logic [WIDTH:0]   pr_next;
  logic             q_bit;

  // One restoring step: shift in the next dividend bit and trial-subtract.
  // pr < divisor holds between steps, so pr_shift < 2*divisor fits in WIDTH+1.
  always_comb begin
    pr_shift = {pr[WIDTH-1:0], sr[WIDTH-1]};
    q_bit    = (pr_shift >= {1'b0, dvs});
    pr_next  = q_bit ? (pr_shift - {1'b0, dvs}) : pr_shift;
  end

  // Control FSM, iteration datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      pr          <= '0;
      sr          <= '0;
      dvs         <= '0;
      cnt         <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE, DONE: begin
          state <= IDLE;
          if (start) begin
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            if (divisor == '0) begin
              // Short-circuit: no iteration, result reported next cycle.
              div_by_zero <= 1'b1;
              quotient    <= '1;
              remainder   <= dividend[WIDTH-1:0];
              done        <= 1'b1;
              state       <= DONE;
            end else if (dividend[2*WIDTH-1:WIDTH] >= divisor) begin
              // High half already >= divisor: quotient cannot fit in WIDTH bits.
              overflow  <= 1'b1;
              quotient  <= '1;
              remainder <= '0;
              done      <= 1'b1;
              state     <= DONE;
            end else begin
              pr    <= {1'b0, dividend[2*WIDTH-1:WIDTH]};
              sr    <= dividend[WIDTH-1:0];
              dvs   <= divisor;
              cnt   <= '0;
              busy  <= 1'b1;
              state <= CALC;
            end
          end
        end
        CALC: begin
          pr  <= pr_next;
          sr  <= {sr[WIDTH-2:0], q_bit};
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(WIDTH - 1)) begin
            quotient  <= {sr[WIDTH-2:0], q_bit};
            remainder <= pr_next[WIDTH-1:0];
            busy      <= 1'b0;
            done      <= 1'b1;
            state     <= DONE;
          end
        end
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
